de_3_to_8: RTL and testbench

Registered 3-to-8 line decoder: a 3-bit binary select becomes a one-hot 8-bit output. It is used wherever a small binary index must drive one of eight enables, such as bank selects, row strobes or interrupt routing. The output is registered on a single clock so downstream logic sees glitch-free one-hot strobes. A parameter selects active-high or active-low output polarity.

---
 rtl/de_3_to_8.sv | 57 +++++
 tb/tb_de_3_to_8.sv | 137 +++++++++++++
 2 files changed

// File: rtl/de_3_to_8.sv
// -----------------------------------------------------------------------------
// de_3_to_8
// Registered 3-to-8 line decoder. A 3-bit binary select is turned into a
// one-hot (or, with ACTIVE_LOW=1, one-cold) 8-bit strobe vector. The output
// is taken straight from flops, so downstream enables never see glitches.
//
// Parameters:
//   ACTIVE_LOW  - 0: selected bit is 1, others 0.
//                 1: selected bit is 0, others 1.
//
// Ports:
//   clk         - single clock, all state updates on the rising edge
//   rst         - synchronous, active-high reset
//   in          - binary select, 0..7
//   decoder_out - registered decoded output (1 cycle after `in` is sampled)
//   out_valid   - high once decoder_out holds a decode rather than the
//                 reset "no selection" value
// -----------------------------------------------------------------------------
module de_3_to_8 #(
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in,
    output logic [7:0] decoder_out,
    output logic       out_valid
);

    // Reset value: no line selected in the chosen polarity.
    localparam logic [7:0] NoSel = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [7:0] onehot;
    logic [7:0] dec_d;
    logic [7:0] dec_q;
    logic       valid_q;

    always_comb begin
        onehot     = 8'h00;
        onehot[in] = 1'b1;
        dec_d      = (ACTIVE_LOW != 0) ? ~onehot : onehot;
    end

    // Reset wins over decode on the same edge; no partial update.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q   <= NoSel;
            valid_q <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            valid_q <= 1'b1;
        end
    end

    assign decoder_out = dec_q;
    assign out_valid   = valid_q;

endmodule

// File: tb/tb_de_3_to_8.sv
// -----------------------------------------------------------------------------
// tb_de_3_to_8
// Directed bench for de_3_to_8 with one active-high and one active-low
// instance sharing clock and reset. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_de_3_to_8;

    logic       clk;
    logic       rst;
    logic [2:0] in_h;
    logic [2:0] in_l;
    logic [7:0] out_h;
    logic [7:0] out_l;
    logic       vld_h;
    logic       vld_l;

    int n_checks = 0;
    int n_errors = 0;

    de_3_to_8 #(.ACTIVE_LOW(0)) u_dut_h (
        .clk         (clk),
        .rst         (rst),
        .in          (in_h),
        .decoder_out (out_h),
        .out_valid   (vld_h)
    );

    de_3_to_8 #(.ACTIVE_LOW(1)) u_dut_l (
        .clk         (clk),
        .rst         (rst),
        .in          (in_l),
        .decoder_out (out_l),
        .out_valid   (vld_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] b2b_in  [4];
    logic [7:0] b2b_exp [4];
    logic [7:0] e;

    initial begin
        b2b_in  = '{3'd7, 3'd0, 3'd3, 3'd4};
        b2b_exp = '{8'h80, 8'h01, 8'h08, 8'h10};

        // Reset held for two cycles with in=5.
        rst  = 1'b1;
        in_h = 3'd5;
        in_l = 3'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_out_h", out_h, 8'h00);
            check("rst_vld_h", {7'd0, vld_h}, 8'h00);
            check("rst_out_l", out_l, 8'hFF);
            check("rst_vld_l", {7'd0, vld_l}, 8'h00);
        end

        // First edge out of reset decodes the held input.
        rst = 1'b0;
        step();
        check("first_out_h", out_h, 8'h20);
        check("first_vld_h", {7'd0, vld_h}, 8'h01);
        check("first_out_l", out_l, 8'hFE);

        // Exhaustive sweep, each value held for 10 cycles.
        for (int v = 0; v < 8; v++) begin
            in_h = v[2:0];
            e    = 8'h01 << v;
            for (int c = 0; c < 10; c++) begin
                step();
                check("sweep_out", out_h, e);
                if (vld_h) check("sweep_onehot", {7'd0, $onehot(out_h)}, 8'h01);
            end
        end

        // Back-to-back changes every cycle.
        for (int i = 0; i < 4; i++) begin
            in_h = b2b_in[i];
            step();
            check("b2b_out", out_h, b2b_exp[i]);
        end

        // Toggle between edges; only the value at the edge (2) may land.
        in_h = 3'd6;
        #2 in_h = 3'd2;
        #2 in_h = 3'd6;
        #2 in_h = 3'd2;
        #1 check("glitch_hold", out_h, 8'h10);
        step();
        check("glitch_out", out_h, 8'h04);

        // One-cycle reset in the middle of a stream.
        in_h = 3'd3;
        step();
        check("mid_pre", out_h, 8'h08);
        rst = 1'b1;
        step();
        check("mid_rst_out", out_h, 8'h00);
        check("mid_rst_vld", {7'd0, vld_h}, 8'h00);
        check("mid_rst_out_l", out_l, 8'hFF);
        rst = 1'b0;
        step();
        check("mid_resume", out_h, 8'h08);
        check("mid_resume_vld", {7'd0, vld_h}, 8'h01);

        // Active-low mapping.
        in_l = 3'd0;
        step();
        check("al_in0", out_l, 8'hFE);
        in_l = 3'd7;
        step();
        check("al_in7", out_l, 8'h7F);
        in_l = 3'd4;
        step();
        check("al_in4", out_l, 8'hEF);
        check("al_vld", {7'd0, vld_l}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
